// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - round-robin arbiter sharing one AES core between requesters
module aes_core_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                       AES_clk,
  input  logic                       AES_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*128-1:0]     req_data,
  input  logic [NUM_REQ*128-1:0]     req_key,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [127:0]               rsp_data,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       core_en,
  output logic [127:0]               core_data_in,
  output logic [127:0]               core_key_in,
  input  logic [127:0]               core_data_out,
  input  logic                       core_data_out_valid
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, GAP} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   run_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   pick_next;
  logic [127:0]    sel_data;
  logic [127:0]    sel_key;
  logic            run_timeout;

  // First asserted request at or after rr_ptr, wrapping around.
  always_comb begin
    int j;
    found    = 1'b0;
    pick     = '0;
    sel_data = '0;
    sel_key  = '0;
    j        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_valid[j]) begin
        found    = 1'b1;
        pick     = IW'(j);
        sel_data = req_data[128*j +: 128];
        sel_key  = req_key[128*j +: 128];
      end
    end
  end

  assign pick_next   = (int'(pick) == NUM_REQ - 1) ? '0 : pick + IW'(1);
  assign run_timeout = (run_cnt == CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_n   = state;
    req_ready = '0;
    rsp_valid = '0;
    core_en   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (found) begin
          state_n = RUN;
          if (!AES_rst) req_ready = NUM_REQ'(1) << pick;
        end
      end
      RUN: begin
        core_en = 1'b1;
        if (core_data_out_valid || run_timeout) state_n = DONE;
      end
      DONE: begin
        state_n = GAP;
        if (!AES_rst) rsp_valid = NUM_REQ'(1) << grant_id;
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      run_cnt      <= '0;
      gap_cnt      <= '0;
      grant_id     <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      core_data_in <= '0;
      core_key_in  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (found) begin
            core_data_in <= sel_data;
            core_key_in  <= sel_key;
            grant_id     <= pick;
            rr_ptr       <= pick_next;
            run_cnt      <= CW'(1);
          end
        end
        RUN: begin
          // A valid arriving on the timeout cycle still counts as success.
          if (core_data_out_valid) begin
            rsp_data <= core_data_out;
            rsp_err  <= 1'b0;
          end else if (run_timeout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            run_cnt <= run_cnt + CW'(1);
          end
        end
        DONE: gap_cnt <= GW'(1);
        GAP:  gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb/tb_aes_core_arbiter.sv - directed bench for aes_core_arbiter with a latency-programmable core stub
module tb_aes_core_arbiter;
  localparam int N = 4;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic               AES_clk = 1'b0;
  logic               AES_rst;
  logic [N-1:0]       req_valid;
  logic [N*128-1:0]   req_data;
  logic [N*128-1:0]   req_key;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       rsp_valid;
  logic [127:0]       rsp_data;
  logic               rsp_err;
  logic               busy;
  logic [1:0]         grant_id;
  logic               core_en;
  logic [127:0]       core_data_in;
  logic [127:0]       core_key_in;
  logic [127:0]       core_data_out;
  logic               core_data_out_valid;

  int lat = 0;
  int stub_cnt = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 AES_clk = ~AES_clk;

  aes_core_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(64), .GAP_CYCLES(2)) dut (
    .AES_clk(AES_clk), .AES_rst(AES_rst),
    .req_valid(req_valid), .req_data(req_data), .req_key(req_key), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id),
    .core_en(core_en), .core_data_in(core_data_in), .core_key_in(core_key_in),
    .core_data_out(core_data_out), .core_data_out_valid(core_data_out_valid)
  );

  // Core stand-in: known AES vector for the reference pair, a cheap mix otherwise.
  function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k);
    if (d == PT1 && k == KEY1) return CT1;
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0000_ffff_1234_a5a5_c3c3_0f0f_9999;
  endfunction

  always @(posedge AES_clk) begin
    cyc      <= cyc + 1;
    stub_cnt <= core_en ? stub_cnt + 1 : 0;
  end
  assign core_data_out_valid = core_en && (lat != 0) && (stub_cnt + 1 == lat);
  assign core_data_out = core_data_out_valid ? model(core_data_in, core_key_in) : '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge AES_clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (req_ready == '0 && n < 300) begin tick(); n++; end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 300) begin tick(); n++; end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    chk("idle_reached", 128'(busy), 128'(0));
  endtask

  task automatic do_reset;
    AES_rst   = 1'b1;
    req_valid = '0;
    tick();
    tick();
    AES_rst = 1'b0;
    #1;
  endtask

  function automatic logic [127:0] dat(input int i);
    return 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210 ^ 128'(i * 32'h1111_0001);
  endfunction

  function automatic logic [127:0] kk(input int i);
    return 128'hdead_beef_cafe_f00d_0bad_c0de_1357_9bdf + 128'(i);
  endfunction

  initial begin
    int n;
    int last;
    int exp_g;
    req_data = '0;
    req_key  = '0;
    do_reset();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_core_en", 128'(core_en), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_data", rsp_data, 128'(0));
    chk("rst_rsp_err", 128'(rsp_err), 128'(0));
    chk("rst_grant_id", 128'(grant_id), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_core_data_in", core_data_in, 128'(0));

    // single job with the reference vector
    lat = 10;
    req_data[0 +: 128] = PT1;
    req_key[0 +: 128]  = KEY1;
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 128'(req_ready), 128'(4'b0001));
    tick();
    req_valid = '0;
    chk("t1_core_en", 128'(core_en), 128'(1));
    chk("t1_busy", 128'(busy), 128'(1));
    chk("t1_core_data_in", core_data_in, PT1);
    chk("t1_core_key_in", core_key_in, KEY1);
    wait_rsp(n);
    chk("t1_latency", 128'(n), 128'(10));
    chk("t1_rsp_valid", 128'(rsp_valid), 128'(4'b0001));
    chk("t1_rsp_data", rsp_data, CT1);
    chk("t1_rsp_err", 128'(rsp_err), 128'(0));
    chk("t1_done_core_en", 128'(core_en), 128'(0));
    tick();
    chk("t1_gap_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("t1_gap_hold_data", rsp_data, CT1);
    chk("t1_gap_hold_din", core_data_in, PT1);
    wait_idle();

    // all four requesting after reset: grants 0..3, spacing latency+2+gap
    do_reset();
    lat = 3;
    for (int i = 0; i < N; i++) begin
      req_data[128*i +: 128] = dat(i);
      req_key[128*i +: 128]  = kk(i);
    end
    req_valid = 4'b1111;
    #1;
    last = 0;
    for (int g = 0; g < N; g++) begin
      wait_ready(n);
      chk($sformatf("t2_ready_%0d", g), 128'(req_ready), 128'(4'b0001 << g));
      if (g > 0) chk($sformatf("t2_spacing_%0d", g), 128'(cyc - last), 128'(7));
      last = cyc;
      tick();
      req_valid[g] = 1'b0;
      chk($sformatf("t2_grant_%0d", g), 128'(grant_id), 128'(g));
      wait_rsp(n);
      chk($sformatf("t2_rsp_valid_%0d", g), 128'(rsp_valid), 128'(4'b0001 << g));
      chk($sformatf("t2_rsp_data_%0d", g), rsp_data, model(dat(g), kk(g)));
    end
    wait_idle();

    // requesters 1 and 3 held continuously alternate
    lat = 2;
    req_valid = 4'b1010;
    #1;
    for (int j = 0; j < 8; j++) begin
      exp_g = (j % 2 == 0) ? 1 : 3;
      wait_ready(n);
      chk($sformatf("t3_ready_%0d", j), 128'(req_ready), 128'(4'b0001 << exp_g));
      tick();
      wait_rsp(n);
      chk($sformatf("t3_rsp_valid_%0d", j), 128'(rsp_valid), 128'(4'b0001 << exp_g));
    end
    req_valid = '0;
    wait_idle();

    // core never answers: timeout after 64 RUN cycles, then a normal job
    lat = 0;
    req_valid = 4'b0100;
    #1;
    chk("t4_ready", 128'(req_ready), 128'(4'b0100));
    tick();
    req_valid = '0;
    wait_rsp(n);
    chk("t4_timeout_cycles", 128'(n), 128'(64));
    chk("t4_rsp_valid", 128'(rsp_valid), 128'(4'b0100));
    chk("t4_rsp_err", 128'(rsp_err), 128'(1));
    chk("t4_rsp_data", rsp_data, 128'(0));
    wait_idle();
    lat = 5;
    req_valid = 4'b0100;
    #1;
    chk("t4b_ready", 128'(req_ready), 128'(4'b0100));
    tick();
    req_valid = '0;
    wait_rsp(n);
    chk("t4b_latency", 128'(n), 128'(5));
    chk("t4b_rsp_err", 128'(rsp_err), 128'(0));
    chk("t4b_rsp_data", rsp_data, model(dat(2), kk(2)));
    wait_idle();

    // reset in RUN cycle 5 aborts and clears rr_ptr
    lat = 0;
    req_valid = 4'b1000;
    #1;
    chk("t5_ready", 128'(req_ready), 128'(4'b1000));
    tick();
    req_valid = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_in_run", 128'(core_en), 128'(1));
    AES_rst = 1'b1;
    tick();
    chk("t5_core_en", 128'(core_en), 128'(0));
    chk("t5_busy", 128'(busy), 128'(0));
    chk("t5_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("t5_grant_id", 128'(grant_id), 128'(0));
    AES_rst = 1'b0;
    lat = 4;
    req_valid = 4'b1011;
    #1;
    chk("t5_rr_restart", 128'(req_ready), 128'(4'b0001));
    tick();
    req_valid = '0;
    wait_rsp(n);
    chk("t5_rsp_valid_after", 128'(rsp_valid), 128'(4'b0001));
    wait_idle();

    // valid exactly on the timeout cycle wins; late req_data change ignored
    lat = 64;
    req_data[128 +: 128] = PT1;
    req_key[128 +: 128]  = KEY1;
    req_valid = 4'b0010;
    #1;
    chk("t6_ready", 128'(req_ready), 128'(4'b0010));
    tick();
    req_valid = '0;
    req_data[128 +: 128] = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
    wait_rsp(n);
    chk("t6_latency", 128'(n), 128'(64));
    chk("t6_rsp_valid", 128'(rsp_valid), 128'(4'b0010));
    chk("t6_rsp_err", 128'(rsp_err), 128'(0));
    chk("t6_rsp_data", rsp_data, CT1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
